// File: rtl/reg_cmd_ctrl_pkg.sv
// Shared definitions for the UART register command controller.
// Holds the FSM state encoding and the default write/read opcodes.
package reg_cmd_ctrl_pkg;

  // State encodings, kept as named constants so other blocks can decode them.
  localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
  localparam logic [2:0] ST_WR_ADDR_ENC = 3'd1;
  localparam logic [2:0] ST_WR_DATA_ENC = 3'd2;
  localparam logic [2:0] ST_RD_ADDR_ENC = 3'd3;
  localparam logic [2:0] ST_RD_WAIT_ENC = 3'd4;
  localparam logic [2:0] ST_TX_SEND_ENC = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_WR_ADDR = ST_WR_ADDR_ENC,
    ST_WR_DATA = ST_WR_DATA_ENC,
    ST_RD_ADDR = ST_RD_ADDR_ENC,
    ST_RD_WAIT = ST_RD_WAIT_ENC,
    ST_TX_SEND = ST_TX_SEND_ENC
  } state_t;

  // Default command opcodes.
  localparam logic [7:0] WR_CMD_DEF = 8'hAA;
  localparam logic [7:0] RD_CMD_DEF = 8'hBB;

endpackage : reg_cmd_ctrl_pkg

// File: rtl/reg_cmd_ctrl.sv
// Byte-oriented register command controller.
// Decodes frames from a UART receiver:
//   write: WR_CMD, addr, data   -> one-cycle o_WrEn with o_Address/o_WrData
//   read : RD_CMD, addr         -> one-cycle o_RdEn, capture i_RdData,
//                                  then send it as one o_TX_Valid strobe
// Ports:
//   i_CLK, i_RST (async, active low)
//   i_RX_Data/i_RX_Valid         received byte and strobe
//   o_WrEn/o_RdEn/o_Address/o_WrData, i_RdData/i_RdData_Valid  register file
//   o_TX_Data/o_TX_Valid/i_TX_Busy                              transmitter
//   o_Busy                       high whenever the FSM is not idle
module reg_cmd_ctrl
  import reg_cmd_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WR_CMD     = WR_CMD_DEF,
  parameter logic [DATA_WIDTH-1:0] RD_CMD     = RD_CMD_DEF,
  parameter int                    RD_TIMEOUT = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic [DATA_WIDTH-1:0] i_RX_Data,
  input  logic                  i_RX_Valid,
  output logic                  o_WrEn,
  output logic                  o_RdEn,
  output logic [ADDR_WIDTH-1:0] o_Address,
  output logic [DATA_WIDTH-1:0] o_WrData,
  input  logic [DATA_WIDTH-1:0] i_RdData,
  input  logic                  i_RdData_Valid,
  output logic [DATA_WIDTH-1:0] o_TX_Data,
  output logic                  o_TX_Valid,
  input  logic                  i_TX_Busy,
  output logic                  o_Busy
);

  // Wide enough to count up to RD_TIMEOUT.
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(RD_TIMEOUT - 1);

  state_t                state_q;
  logic                  wr_en_q;
  logic                  rd_en_q;
  logic                  tx_valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [TW-1:0]         tmr_q;

  // Command FSM together with all of its registered datapath outputs.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_q    <= ST_IDLE;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      tx_data_q  <= '0;
      hold_q     <= '0;
      tmr_q      <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_RX_Valid) begin
            if (i_RX_Data == WR_CMD) begin
              state_q <= ST_WR_ADDR;
            end else if (i_RX_Data == RD_CMD) begin
              state_q <= ST_RD_ADDR;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_WR_ADDR: begin
          // Upper address bits of the byte are ignored.
          if (i_RX_Valid) begin
            addr_q  <= i_RX_Data[ADDR_WIDTH-1:0];
            state_q <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (i_RX_Valid) begin
            wr_data_q <= i_RX_Data;
            wr_en_q   <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        ST_RD_ADDR: begin
          if (i_RX_Valid) begin
            addr_q  <= i_RX_Data[ADDR_WIDTH-1:0];
            rd_en_q <= 1'b1;
            tmr_q   <= '0;
            state_q <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          // RX strobes are ignored here; a missing response aborts the read.
          if (i_RdData_Valid) begin
            hold_q  <= i_RdData;
            state_q <= ST_TX_SEND;
          end else if (tmr_q == TMR_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        ST_TX_SEND: begin
          // Wait as long as the transmitter is busy; hold_q keeps the data.
          if (!i_TX_Busy) begin
            tx_data_q  <= hold_q;
            tx_valid_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_WrEn     = wr_en_q;
  assign o_RdEn     = rd_en_q;
  assign o_TX_Valid = tx_valid_q;
  assign o_Address  = addr_q;
  assign o_WrData   = wr_data_q;
  assign o_TX_Data  = tx_data_q;
  assign o_Busy     = (state_q != ST_IDLE);

endmodule : reg_cmd_ctrl
